// File: rtl/amba3_axi_slave_wr_engine.sv
// AXI3 slave write-channel engine: accepts one AW burst at a time and turns
// each W beat into a byte-addressed, lane-masked memory write, then answers on B.
module amba3_axi_slave_wr_engine #(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128,
  parameter int STRB_SIZE = DATA_SIZE / 8
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [TXID_SIZE-1:0] awid,
  input  logic [ADDR_SIZE-1:0] awaddr,
  input  logic [3:0]           awlen,
  input  logic [2:0]           awsize,
  input  logic [1:0]           awburst,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [TXID_SIZE-1:0] wid,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [STRB_SIZE-1:0] wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [TXID_SIZE-1:0] bid,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic [STRB_SIZE-1:0] mem_wstrb
);

  localparam int          LANE_W   = $clog2(STRB_SIZE);
  localparam logic [2:0]  MAX_SIZE = 3'(LANE_W);
  localparam logic [1:0]  BURST_FIXED = 2'd0;
  localparam logic [1:0]  BURST_INCR  = 2'd1;
  localparam logic [1:0]  BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [TXID_SIZE-1:0]   bid_q, bid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [TXID_SIZE-1:0]   id_q, id_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [3:0]             len_q, len_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [ADDR_SIZE-1:0]   size_bytes, aligned, incr_next;
  logic [ADDR_SIZE-1:0]   wbytes, wrap_base, wrap_off, wrap_next;
  logic [ADDR_SIZE-1:0]   aw_size_bytes;
  logic [8:0]             lane_lo, lane_hi;
  logic [STRB_SIZE-1:0]   lane_mask;
  logic                   beat, final_beat, beat_err, cfg_err;

  always_comb begin
    size_bytes = ADDR_SIZE'(1) << size_q;
    aligned    = addr_q & ~(size_bytes - ADDR_SIZE'(1));
    incr_next  = aligned + size_bytes;
    wbytes     = (ADDR_SIZE'(len_q) + ADDR_SIZE'(1)) << size_q;
    wrap_base  = addr_q & ~(wbytes - ADDR_SIZE'(1));
    wrap_off   = aligned + size_bytes - wrap_base;
    wrap_next  = wrap_base + ((wrap_off >= wbytes) ? (wrap_off - wbytes) : wrap_off);

    // Lanes run from the (possibly unaligned) address up to the end of its aligned beat
    lane_lo = 9'(addr_q[LANE_W-1:0]);
    lane_hi = 9'(aligned[LANE_W-1:0]) + (9'd1 << size_q) - 9'd1;
    for (int i = 0; i < STRB_SIZE; i++)
      lane_mask[i] = (9'(i) >= lane_lo) && (9'(i) <= lane_hi);

    aw_size_bytes = ADDR_SIZE'(1) << awsize;
    cfg_err = (awsize > MAX_SIZE) || (awburst == 2'd3) ||
              ((awburst == BURST_WRAP) &&
               (!(awlen == 4'd1 || awlen == 4'd3 || awlen == 4'd7 || awlen == 4'd15) ||
                ((awaddr & (aw_size_bytes - ADDR_SIZE'(1))) != '0)));

    beat       = wvalid & wready_q;
    final_beat = (cnt_q == len_q);
    beat_err   = (wlast != final_beat) || (wid != id_q);
  end

  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (awvalid && awready_q) begin
          id_d      = awid;
          addr_d    = awaddr;
          len_d     = awlen;
          size_d    = awsize;
          burst_d   = awburst;
          cnt_d     = '0;
          err_d     = cfg_err;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 4'd1;
          err_d = err_q | beat_err;
          case (burst_q)
            BURST_INCR: addr_d = incr_next;
            BURST_WRAP: addr_d = wrap_next;
            default:    addr_d = addr_q;
          endcase
          if (final_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q | beat_err) ? 2'b10 : 2'b00;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = beat;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb & lane_mask;

endmodule

// File: tb/tb_amba3_axi_slave_wr_engine.sv
// Scoreboard bench for the AXI3 write engine: expected beats and B responses are
// queued as stimulus is driven and checked when the engine produces them.
module tb_amba3_axi_slave_wr_engine;

  logic         aclk = 1'b0;
  logic         areset_n;
  logic [3:0]   awid, wid, bid;
  logic [31:0]  awaddr, mem_addr;
  logic [3:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst, bresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready, mem_we;
  logic [127:0] wdata, mem_wdata;
  logic [15:0]  wstrb, mem_wstrb;

  typedef struct { logic [31:0] a; logic [15:0] s; logic [127:0] d; } beat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bresp_t;

  beat_t       exp_beats[$];
  bresp_t      exp_b[$];
  logic [31:0] exp_a [16];
  logic [15:0] exp_s [16];
  int          n_vec = 0;
  int          n_err = 0;

  amba3_axi_slave_wr_engine #(.TXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(128)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (mem_we) begin
      n_vec++;
      if (exp_beats.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: mem_addr=%h with no beat expected", mem_addr);
      end else begin
        beat_t e;
        e = exp_beats.pop_front();
        if (mem_addr !== e.a || mem_wstrb !== e.s || mem_wdata !== e.d) begin
          n_err++;
          $display("FAIL beat: got addr=%h strb=%h data=%h, want addr=%h strb=%h data=%h",
                   mem_addr, mem_wstrb, mem_wdata, e.a, e.s, e.d);
        end
      end
    end
    if (bvalid && bready) begin
      n_vec++;
      if (exp_b.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_b: bid=%h bresp=%b with no response expected", bid, bresp);
      end else begin
        bresp_t eb;
        eb = exp_b.pop_front();
        if (bid !== eb.id || bresp !== eb.resp) begin
          n_err++;
          $display("FAIL b_resp: got bid=%h bresp=%b, want bid=%h bresp=%b",
                   bid, bresp, eb.id, eb.resp);
        end
      end
    end
  end

  // Drives one burst; beat addresses/strobes expected come from exp_a/exp_s.
  // abort_after >= 0 drops reset right after that beat instead of finishing.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [15:0] strb,
                           input int wlast_at, input logic [1:0] resp, input bit hold_b,
                           input int abort_after);
    bit hs;
    int t;
    bresp_t eb;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    do begin
      @(negedge aclk); hs = awvalid && awready;
      @(posedge aclk); #1; t++;
    end while (!hs && t < 50);
    awvalid = 1'b0;
    if (!hs) begin
      n_vec++; n_err++;
      $display("FAIL aw_timeout: awready=%b, want 1", awready);
      return;
    end
    if (abort_after < 0) begin
      eb.id = id; eb.resp = resp;
      exp_b.push_back(eb);
    end
    for (int b = 0; b <= int'(len); b++) begin
      beat_t e;
      wid = id; wstrb = strb; wlast = (b == wlast_at); wvalid = 1'b1;
      wdata = {$urandom, $urandom, $urandom, $urandom};
      e.a = exp_a[b]; e.s = exp_s[b]; e.d = wdata;
      exp_beats.push_back(e);
      t = 0;
      do begin
        @(negedge aclk); hs = wvalid && wready;
        @(posedge aclk); #1; t++;
      end while (!hs && t < 50);
      if (!hs) begin
        wvalid = 1'b0;
        n_vec++; n_err++;
        $display("FAIL w_timeout: wready=%b, want 1 on beat %0d", wready, b);
        return;
      end
      if (b == abort_after) begin
        wvalid = 1'b0;
        areset_n = 1'b0;
        #1;
        n_vec++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
          n_err++;
          $display("FAIL abort_reset: awready=%b wready=%b bvalid=%b, want 1 0 0",
                   awready, wready, bvalid);
        end
        exp_beats.delete();
        @(posedge aclk); #1;
        areset_n = 1'b1;
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (hold_b) begin
      bready = 1'b0;
      t = 0;
      do begin @(negedge aclk); t++; end while (!bvalid && t < 20);
      for (int c = 0; c < 5; c++) begin
        n_vec++;
        if (bvalid !== 1'b1 || bid !== id || bresp !== resp) begin
          n_err++;
          $display("FAIL b_hold: cycle %0d bvalid=%b bid=%h bresp=%b, want 1 %h %b",
                   c, bvalid, bid, bresp, id, resp);
        end
        @(negedge aclk);
      end
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    t = 0;
    do begin
      @(negedge aclk); hs = bvalid;
      @(posedge aclk); #1; t++;
    end while (!hs && t < 50);
    bready = 1'b0;
    if (!hs) begin
      n_vec++; n_err++;
      $display("FAIL b_timeout: bvalid=%b, want 1", bvalid);
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    repeat (3) @(posedge aclk);
    #1;
    n_vec++;
    if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 4'h0 ||
        bresp !== 2'b00 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset: awready=%b wready=%b bvalid=%b bid=%h bresp=%b mem_we=%b, want 1 0 0 0 00 0",
               awready, wready, bvalid, bid, bresp, mem_we);
    end
    areset_n = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_incr_unaligned();
    exp_a[0] = 32'h104; exp_a[1] = 32'h108; exp_a[2] = 32'h10C; exp_a[3] = 32'h110;
    exp_s[0] = 16'h00F0; exp_s[1] = 16'h0F00; exp_s[2] = 16'hF000; exp_s[3] = 16'h000F;
    run_burst(4'h5, 32'h104, 4'd3, 3'd2, 2'd1, 16'hFFFF, 3, 2'b00, 1'b0, -1);
  endtask

  task automatic test_wrap();
    exp_a[0] = 32'h704; exp_a[1] = 32'h708; exp_a[2] = 32'h70C; exp_a[3] = 32'h700;
    exp_s[0] = 16'h00F0; exp_s[1] = 16'h0F00; exp_s[2] = 16'hF000; exp_s[3] = 16'h000F;
    run_burst(4'hA, 32'h704, 4'd3, 3'd2, 2'd2, 16'hFFFF, 3, 2'b00, 1'b0, -1);
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 5; i++) begin exp_a[i] = 32'h106; exp_s[i] = 16'h0040; end
    run_burst(4'h3, 32'h106, 4'd4, 3'd0, 2'd0, 16'hFFFF, 4, 2'b00, 1'b0, -1);
  endtask

  task automatic test_incr_size3();
    exp_a[0] = 32'h201; exp_a[1] = 32'h208; exp_a[2] = 32'h210;
    exp_s[0] = 16'h00FE; exp_s[1] = 16'hFF00; exp_s[2] = 16'h00FF;
    run_burst(4'h7, 32'h201, 4'd2, 3'd3, 2'd1, 16'hFFFF, 2, 2'b00, 1'b0, -1);
  endtask

  task automatic test_wlast_error_hold();
    exp_a[0] = 32'h300; exp_a[1] = 32'h304; exp_a[2] = 32'h308; exp_a[3] = 32'h30C;
    exp_s[0] = 16'h000F; exp_s[1] = 16'h00F0; exp_s[2] = 16'h0F00; exp_s[3] = 16'hF000;
    run_burst(4'hC, 32'h300, 4'd3, 3'd2, 2'd1, 16'hFFFF, 1, 2'b10, 1'b1, -1);
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = 32'h400 + 32'(4 * i);
      exp_s[i] = 16'h000F << (4 * (i % 4));
    end
    run_burst(4'h9, 32'h400, 4'd7, 3'd2, 2'd1, 16'hFFFF, 7, 2'b00, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    exp_a[0] = 32'h500; exp_a[1] = 32'h510;
    exp_s[0] = 16'hFFFF; exp_s[1] = 16'hFFFF;
    run_burst(4'h2, 32'h500, 4'd1, 3'd4, 2'd1, 16'hFFFF, 1, 2'b00, 1'b0, -1);
    exp_a[0] = 32'h602; exp_a[1] = 32'h603;
    exp_s[0] = 16'h0004; exp_s[1] = 16'h0008;
    run_burst(4'h1, 32'h602, 4'd1, 3'd0, 2'd1, 16'h00FF, 1, 2'b00, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_incr_unaligned();
    test_wrap();
    test_fixed();
    test_incr_size3();
    test_wlast_error_hold();
    test_reset_abort();
    test_back_to_back();
    repeat (5) @(posedge aclk);
    #1;
    n_vec++;
    if (exp_beats.size() != 0 || exp_b.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d beats and %0d responses outstanding, want 0 and 0",
               exp_beats.size(), exp_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
